// File: rtl/rr_req_buffer_pkg.sv
// Shared definitions for the request buffer and the round-robin arbiter it feeds.
// Holds default sizing constants and a constant-foldable ceiling log2.
package rr_req_buffer_pkg;

   localparam int NREQ_DEF  = 2;
   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 4;

   function automatic int clog2(input int n);
      int r;
      for (r = 0; (1 << r) < n; r++) begin
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_req_buffer_sync_fifo.sv
// Single-clock FIFO for one requester.
// Head data is presented combinationally on dout; push/pop are ignored when full/empty.
module sync_fifo
   import rr_req_buffer_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // DEPTH is a power of two, so pointer wrap is plain overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rr_req_buffer.sv
// Per-requester FIFOs feeding a round-robin arbiter; the granted FIFO head is
// moved into a single registered output slot with a valid/ready handshake.
module rr_req_buffer
   import rr_req_buffer_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int SW    = (NREQ > 1) ? clog2(NREQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    in_valid,
   output logic [NREQ-1:0]    in_ready,
   input  logic [NREQ*DW-1:0] in_data,
   output logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    grant,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DW-1:0]      out_data,
   output logic [SW-1:0]      out_src,
   output logic               err_grant
);

   localparam int CW = clog2(DEPTH) + 1;

   logic [DW-1:0]   head     [NREQ];
   logic [CW-1:0]   fifo_cnt [NREQ];
   logic [NREQ-1:0] fifo_full;
   logic [NREQ-1:0] fifo_empty;
   logic [NREQ-1:0] push_vec;
   logic [NREQ-1:0] pop_vec;
   logic [NREQ-1:0] gr;
   logic [SW-1:0]   sel;
   logic            pop_any;
   logic            slot_free;
   logic            grant_multi;
   logic            grant_stray;

   assign slot_free = !out_valid || out_ready;

   for (genvar i = 0; i < NREQ; i++) begin : g_fifo
      assign in_ready[i] = !fifo_full[i];
      assign push_vec[i] = in_valid[i] && in_ready[i];
      assign req[i]      = !fifo_empty[i] && slot_free;

      sync_fifo #(
         .DW    (DW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push_vec[i]),
         .pop   (pop_vec[i]),
         .din   (in_data[i*DW +: DW]),
         .dout  (head[i]),
         .count (fifo_cnt[i]),
         .full  (fifo_full[i]),
         .empty (fifo_empty[i])
      );

      always_comb begin
         assert (fifo_full[i] == (fifo_cnt[i] == CW'(DEPTH)));
      end
   end

   // Only granted bits that are also requested can pop; lowest index wins a collision
   assign gr      = grant & req;
   assign pop_vec = gr & (~gr + NREQ'(1));

   always_comb begin
      pop_any = 1'b0;
      sel     = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (gr[i]) begin
            pop_any = 1'b1;
            sel     = SW'(i);
         end
      end
   end

   assign grant_multi = ((grant & (grant - NREQ'(1))) != '0) && slot_free;
   assign grant_stray = (grant & ~req) != '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else if (pop_any) begin
         out_valid <= 1'b1;
         out_data  <= head[sel];
         out_src   <= sel;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_grant <= 1'b0;
      end else if (grant_multi || grant_stray) begin
         err_grant <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rr_req_buffer.sv
// Directed bench for rr_req_buffer with a small round-robin arbiter model
// selectable against pass-through, forced and idle grant modes.
module tb_rr_req_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  in_valid = '0;
   logic [1:0]  in_ready;
   logic [15:0] in_data = '0;
   logic [1:0]  req;
   logic [1:0]  grant;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic [0:0]  out_src;
   logic        err_grant;

   // grant modes: 0 = grant follows req, 1 = round-robin, 2 = forced, 3 = none
   int          mode = 3;
   logic [1:0]  force_g = '0;
   logic [1:0]  rr_g;
   logic        last = 1'b0;

   int          n_chk = 0;
   int          n_pass = 0;

   rr_req_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .req       (req),
      .grant     (grant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .err_grant (err_grant)
   );

   always #5 clk = ~clk;

   always_comb begin
      rr_g = '0;
      if (last == 1'b0) begin
         if (req[1])      rr_g = 2'b10;
         else if (req[0]) rr_g = 2'b01;
      end else begin
         if (req[0])      rr_g = 2'b01;
         else if (req[1]) rr_g = 2'b10;
      end
   end

   always_comb begin
      grant = '0;
      case (mode)
         0:       grant = req;
         1:       grant = rr_g;
         2:       grant = force_g;
         default: grant = '0;
      endcase
   end

   always @(posedge clk or posedge rst) begin
      if (rst)                          last <= 1'b0;
      else if (mode == 1 && grant != 0) last <= grant[1];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset values
      #12;
      check("rst_in_ready", 32'(in_ready), 32'h3);
      check("rst_req", 32'(req), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data", 32'(out_data), 32'h0);
      check("rst_out_src", 32'(out_src), 32'h0);
      check("rst_err", 32'(err_grant), 32'h0);
      rst = 1'b0;

      // reset mid-traffic: slot full with 01, FIFO0 holding 02..04
      tick();
      mode = 0;
      out_ready = 1'b0;
      in_valid = 2'b01;
      for (int k = 1; k <= 4; k++) begin
         in_data[7:0] = 8'(k);
         tick();
      end
      in_valid = '0;
      check("mid_out_valid", 32'(out_valid), 32'h1);
      check("mid_req_bp", 32'(req), 32'h0);
      check("mid_out_data", 32'(out_data), 32'h01);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'h0);
      check("arst_req", 32'(req), 32'h0);
      check("arst_in_ready", 32'(in_ready), 32'h3);
      check("arst_out_data", 32'(out_data), 32'h0);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      tick();
      check("post_rst_empty", 32'(req), 32'h0);
      check("post_rst_valid", 32'(out_valid), 32'h0);

      // single requester, 2-edge latency then back-to-back
      in_valid = 2'b01;
      in_data[7:0] = 8'hA1;
      tick();
      check("lat_req", 32'(req), 32'h1);
      check("lat_valid_e1", 32'(out_valid), 32'h0);
      in_data[7:0] = 8'hA2;
      tick();
      check("s_data1", 32'(out_data), 32'hA1);
      check("s_valid1", 32'(out_valid), 32'h1);
      check("s_src1", 32'(out_src), 32'h0);
      in_data[7:0] = 8'hA3;
      tick();
      check("s_data2", 32'(out_data), 32'hA2);
      in_valid = '0;
      tick();
      check("s_data3", 32'(out_data), 32'hA3);
      check("s_valid3", 32'(out_valid), 32'h1);
      tick();
      check("s_drained", 32'(out_valid), 32'h0);

      // alternation under round-robin
      mode = 3;
      in_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         in_data = {8'(8'h20 + k), 8'(8'h10 + k)};
         tick();
      end
      in_valid = '0;
      check("alt_full", 32'(in_ready), 32'h0);
      mode = 1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("alt_src%0d", k), 32'(out_src), (k % 2 == 0) ? 32'h1 : 32'h0);
         check($sformatf("alt_data%0d", k), 32'(out_data),
               (k % 2 == 0) ? 32'(8'h20 + k / 2) : 32'(8'h10 + k / 2));
      end
      check("alt_err", 32'(err_grant), 32'h0);

      // backpressure: slot holds 13
      out_ready = 1'b0;
      tick();
      check("bp_req", 32'(req), 32'h0);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_data", 32'(out_data), 32'h13);
      in_valid = 2'b10;
      for (int k = 0; k < 4; k++) begin
         in_data[15:8] = 8'(8'h30 + k);
         tick();
      end
      check("bp_full1", 32'(in_ready), 32'h1);
      in_data[15:8] = 8'h34;
      tick();
      check("bp_drop_ready", 32'(in_ready), 32'h1);
      check("bp_hold_data", 32'(out_data), 32'h13);
      check("bp_hold_req", 32'(req), 32'h0);
      in_valid = '0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("bp_drain%0d", k), 32'(out_data), 32'(8'h30 + k));
         check($sformatf("bp_src%0d", k), 32'(out_src), 32'h1);
      end
      tick();
      check("bp_no_fifth", 32'(out_valid), 32'h0);

      // full FIFO0 with simultaneous push and pop
      mode = 3;
      in_valid = 2'b01;
      for (int k = 0; k < 4; k++) begin
         in_data[7:0] = 8'(8'h40 + k);
         tick();
      end
      in_data[7:0] = 8'h44;
      check("fp_full0", 32'(in_ready), 32'h2);
      mode = 0;
      tick();
      check("fp_pop", 32'(out_data), 32'h40);
      check("fp_cnt3", 32'(in_ready), 32'h3);
      in_valid = '0;
      for (int k = 1; k < 4; k++) begin
         tick();
         check($sformatf("fp_drain%0d", k), 32'(out_data), 32'(8'h40 + k));
      end
      tick();
      check("fp_rejected", 32'(out_valid), 32'h0);

      // illegal grant
      mode = 3;
      in_valid = 2'b11;
      in_data = {8'h60, 8'h50};
      tick();
      in_valid = '0;
      check("ig_pre_err", 32'(err_grant), 32'h0);
      check("ig_req", 32'(req), 32'h3);
      mode = 2;
      force_g = 2'b11;
      tick();
      mode = 3;
      check("ig_data", 32'(out_data), 32'h50);
      check("ig_src", 32'(out_src), 32'h0);
      check("ig_err", 32'(err_grant), 32'h1);
      check("ig_fifo1_kept", 32'(req), 32'h2);
      tick();
      check("ig_sticky1", 32'(err_grant), 32'h1);
      mode = 0;
      tick();
      check("ig_fifo1_data", 32'(out_data), 32'h60);
      check("ig_fifo1_src", 32'(out_src), 32'h1);
      check("ig_sticky2", 32'(err_grant), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
